// File: rtl/msg_schedule_ctrl.sv
// msg_schedule_ctrl: SHA-256 message schedule sequencer, loads 16 words and emits W[0..63].
// Optional MSG_SCHED_STALL_CNT_EN adds a saturating output-stall cycle counter (stall_cnt).
module mod_s1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module mod_s0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module msg_schedule_ctrl #(
    parameter int NWORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:31] w_in,
    input  logic        w_in_valid,
    output logic        w_in_ready,
    output logic [0:31] w_out,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [5:0]  t_out,
    output logic        busy,
`ifdef MSG_SCHED_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        done
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    state_t      state;
    logic [31:0] win [16];
    logic [3:0]  cnt;
    logic [31:0] s1, s0, nxt;

    mod_s1 u_s1 (.x(win[14]), .y(s1));
    mod_s0 u_s0 (.x(win[1]),  .y(s0));

    // the last 16 shift-ins are never emitted, so they are forced to zero
    assign nxt   = (t_out >= 6'(NWORDS - 16)) ? 32'd0 : s1 + win[9] + s0 + win[0];
    assign w_out = win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            for (int i = 0; i < 16; i++) win[i] <= 32'd0;
            cnt         <= 4'd0;
            t_out       <= 6'd0;
            w_in_ready  <= 1'b0;
            w_out_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef MSG_SCHED_STALL_CNT_EN
            stall_cnt   <= 16'd0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_LOAD;
                    w_in_ready <= 1'b1;
                    busy       <= 1'b1;
                    cnt        <= 4'd0;
`ifdef MSG_SCHED_STALL_CNT_EN
                    stall_cnt  <= 16'd0;
`endif
                end
                S_LOAD: if (w_in_valid) begin
                    win[cnt] <= w_in;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state       <= S_RUN;
                        w_in_ready  <= 1'b0;
                        w_out_valid <= 1'b1;
                        t_out       <= 6'd0;
                    end
                end
                S_RUN: begin
                    if (w_out_ready) begin
                        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= nxt;
                        t_out   <= t_out + 6'd1;
                        if (t_out == 6'(NWORDS - 1)) begin
                            state       <= S_DONE;
                            w_out_valid <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
`ifdef MSG_SCHED_STALL_CNT_EN
                    else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/msg_schedule_ctrl.md
Name: msg_schedule_ctrl

Overview:
- Sequences the SHA-256 message schedule: accepts one 512-bit block as 16 serial 32-bit words and emits W[0..63], one word per handshake.
- Holds a 16-word sliding window and uses the existing MOD_S1 (σ1) and MOD_S0 (σ0) combinational blocks to generate W[16..63].
- Sits between the block-padding front end and the compression round engine, which consumes W[t] with valid/ready.

Parameters:
- NWORDS, 64, number of schedule words emitted per block (fixed 64 for SHA-256; used for counter compare only).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle pulse; begins a block. Honoured only in IDLE.
- W_IN  input  32  message word, declared [0:31], bit 0 = MSB.
- W_IN_VALID  input  1  W_IN is valid.
- W_IN_READY  output  1  block accepts W_IN (LOAD state only).
- W_OUT  output  32  schedule word W[T_OUT], declared [0:31], bit 0 = MSB.
- W_OUT_VALID  output  1  W_OUT/T_OUT are valid.
- W_OUT_READY  input  1  consumer accepts W_OUT.
- T_OUT  output  6  index t of the word on W_OUT.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse after W[63] is accepted.

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-low, RST_N.
- Reset: state=IDLE; window regs WIN[0..15]=0; load count=0; T_OUT=0; W_IN_READY=0; W_OUT_VALID=0; BUSY=0; DONE=0. W_OUT=WIN[0]=0.
- A reset asserted mid-block discards the block immediately; no DONE is generated.
- States:
  - IDLE: START -> LOAD.
  - LOAD: W_IN_READY=1. Each W_IN_VALID&&W_IN_READY writes WIN[cnt]=W_IN and increments cnt. The accept with cnt==15 -> RUN, and clears cnt.
  - RUN: W_OUT_VALID=1, W_OUT=WIN[0], T_OUT=t. On W_OUT_VALID&&W_OUT_READY the window shifts (WIN[i]<=WIN[i+1]) and t increments.
  - Shift-in value WIN[15]<=σ1(WIN[14])+WIN[9]+σ0(WIN[1])+WIN[0], mod 2^32 (carries beyond bit 0 dropped). When t>=48 the shift-in value is 0 (don't-care, forced 0 for determinism).
  - Accept with t==63 -> DONE state. DONE: DONE=1 for exactly one cycle, then -> IDLE.
- σ1 = ROTR17^ROTR19^SHR10 via MOD_S1; σ0 = ROTR7^ROTR18^SHR3 via MOD_S0. Both are combinational; the adder is combinational into the WIN[15] register.
- Latency: W[0] is valid the cycle after the 16th W_IN accept. With READY held high, throughput is 1 word/cycle, so 64 consecutive cycles emit W[0..63].
- Stalls: with W_OUT_READY=0, W_OUT/T_OUT/WIN hold stable and W_OUT_VALID stays 1; there are no bubbles.
- START outside IDLE is ignored. W_IN_VALID outside LOAD is ignored (W_IN_READY=0).
- Simultaneous START with DONE pulse: ignored (state is DONE, not IDLE). START is accepted the following cycle.

Optional Feature:
- Macro MSG_SCHED_STALL_CNT_EN.
- Defined: adds output STALL_CNT[15:0], counting cycles with W_OUT_VALID&&!W_OUT_READY. Saturates at 0xFFFF, clears on accepted START and on reset, and holds after DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- "abc" block: W_IN = 0x61626380, fourteen 0x00000000, then 0x00000018; READY=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB. DONE pulses one cycle after the T_OUT=63 accept.
- σ1 path: W[14]=0xFFFFFFFF, all other words 0 -> W[16]=0x003FFFFF.
- Backpressure: W_OUT_READY toggled randomly and held low 5 cycles at t=20 -> W_OUT/T_OUT stable while stalled, the full sequence matches the no-stall run, and STALL_CNT (if enabled) equals the total stall cycles.
- W_IN_VALID gaps: insert 3 idle cycles between words 7 and 8 -> identical W[0..63]. Extra W_IN_VALID during RUN is not accepted.
- Reset mid-RUN: assert RST_N=0 at t=30 -> all outputs return to reset values asynchronously and no DONE pulse occurs. A new "abc" block afterwards reproduces the first test's results.
- START pulsed during LOAD and RUN -> no effect on the sequence; BUSY stays 1 until IDLE.
